jtkunio_paldma: RTL and testbench
=================================

// Module: jtkunio_paldma
// PURPOSE
// - Palette loader: copies LEN palette bytes from a ROM/SDRAM read port into the palette RAM write port of jtkunio_colmix.
// - Writer side of the palette interface. Sits between the CPU palette bus and the colmix pal_cs/cpu_wrn/cpu_addr/cpu_dout inputs.
// - Transfers run only during vertical blank. CPU accesses always have priority.
// PARAMETERS
// - AW      9   palette address width (colmix palette RAM is 2^9 bytes)
// - ROM_AW  17  ROM byte address width
// - LEN     512 bytes per transfer, 1..2^AW
// PORTS
// - clk        in   1       system clock
// - rst_n      in   1       asynchronous reset, active-low
// - LVBL       in   1       vertical blank, low during blank
// - start      in   1       one-cycle request to load a palette
// - base       in   ROM_AW  ROM source address, sampled when start is accepted
// - rom_cs     out  1       ROM read request
// - rom_addr   out  ROM_AW  ROM byte address
// - rom_data   in   8       ROM read data, valid when rom_ok=1
// - rom_ok     in   1       ROM data valid for the current rom_addr
// - cpu_pal_cs in   1       CPU palette chip select (passthrough)
// - cpu_wrn    in   1       CPU write strobe, active-low (passthrough)
// - cpu_addr   in   AW      CPU palette address (passthrough)
// - cpu_dout   in   8       CPU write data (passthrough)
// - pal_cs     out  1       to colmix pal_cs
// - pal_wrn    out  1       to colmix cpu_wrn
// - pal_addr   out  AW      to colmix cpu_addr
// - pal_din    out  8       to colmix cpu_dout
// - busy       out  1       high from start acceptance until done
// - done       out  1       one-cycle pulse after the last byte is written
// BEHAVIOUR
// - Reset values (async, immediate): state IDLE; rom_cs=0; rom_addr=0; busy=0; done=0; index=0. Registered pal_* are 0, except pal_wrn=1.
// - FSM states: IDLE, WAITVB, REQ, WR, FIN.
//   - IDLE: on start, latch base, set index=0 and busy=1. Go to REQ if LVBL=0, else WAITVB. start is ignored in every other state.
//   - WAITVB: on LVBL=0, go to REQ.
//   - REQ: rom_cs=1, rom_addr=base_l+index. Hold both until rom_ok=1, then capture rom_data and go to WR. rom_ok while rom_cs=0 is ignored.
//   - WR: issue one write cycle with pal_cs=1, pal_wrn=0, pal_addr=index[AW-1:0], pal_din=captured byte.
//     - If cpu_pal_cs=1 in that cycle, the write is deferred and WR retries on the next cycle.
//     - When the write is issued: if index==LEN-1, go to FIN; else index+1 and go to REQ.
//   - FIN: done=1 for one cycle, busy=0, return to IDLE.
// - Blank end (LVBL rises) while in REQ or WR:
//   - A pending ROM request completes first (rom_cs is never dropped before rom_ok).
//   - A write already in WR is still issued.
//   - Then go to WAITVB; resume at the current index in the next blank. No byte is skipped or duplicated.
// - Mux:
//   - cpu_pal_cs=1: pal_* = CPU inputs, registered by one cycle (fixed 1-cycle latency for CPU reads/writes through this block).
//   - No CPU access and no DMA write: pal_cs=0, pal_wrn=1.
// - rom_addr arithmetic is modulo 2^ROM_AW; base+index wraps silently. index width is AW+1, so LEN=2^AW is reachable.
// - done and start in the same cycle: start is ignored (state is FIN, not IDLE).
// STRUCTURE
// - Shared package jtkunio_pkg: FSM state enum, PAL_AW=9 constant, default LEN.
// - One sub-module, jtkunio_paldma_mux: registered CPU/DMA arbitration for the pal_* bus, with CPU priority and a defer flag back to the FSM.
// TESTING
// - LVBL=0, start, base=0x100, rom_ok 2 cycles after each rom_cs -> 512 writes, pal_addr 0..511 with data ROM[0x100+i]; one done pulse; busy low afterwards.
// - start while LVBL=1 -> rom_cs stays 0 until LVBL falls; first rom_addr=base.
// - LVBL rises after 200 bytes -> pause; next blank resumes at pal_addr 200; total 512 unique writes.
// - cpu_pal_cs=1, cpu_wrn=0 held 3 cycles during WR -> CPU writes pass through 1 cycle late; DMA write lands on the 4th cycle, unmodified.
// - rst_n low mid-REQ -> rom_cs=0, busy=0, pal_wrn=1 immediately; a later start restarts from index 0.
// - base=0x1FFF0 with ROM_AW=17 -> rom_addr wraps to 0x00000 after 0x1FFFF; start pulsed while busy -> no restart.

Source files
------------

// File: rtl/jtkunio_pkg.sv
// Shared types and constants for the jtkunio palette loader.
package jtkunio_pkg;

    localparam int unsigned PAL_AW  = 9;
    localparam int unsigned DEF_LEN = 512;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAITVB = 3'd1,
        REQ    = 3'd2,
        WR     = 3'd3,
        FIN    = 3'd4
    } paldma_state_t;

endpackage

// File: rtl/jtkunio_paldma_mux.sv
// Registered arbitration of the colmix palette bus between the CPU and the loader.
// The CPU always wins; the loader is told to hold its write for another cycle.
module jtkunio_paldma_mux
    import jtkunio_pkg::*;
#(
    parameter int unsigned AW = PAL_AW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_pal_cs,
    input  logic          cpu_wrn,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_data,
    output logic          defer_c,
    output logic          pal_cs,
    output logic          pal_wrn,
    output logic [AW-1:0] pal_addr,
    output logic [7:0]    pal_din
);

    // A loader write collides with any CPU access in the same cycle
    assign defer_c = dma_req & cpu_pal_cs;

    // One-cycle registered bus: CPU first, then loader write, else idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_cs   <= 1'b0;
            pal_wrn  <= 1'b1;
            pal_addr <= '0;
            pal_din  <= '0;
        end else if (cpu_pal_cs) begin
            pal_cs   <= 1'b1;
            pal_wrn  <= cpu_wrn;
            pal_addr <= cpu_addr;
            pal_din  <= cpu_dout;
        end else if (dma_req) begin
            pal_cs   <= 1'b1;
            pal_wrn  <= 1'b0;
            pal_addr <= dma_addr;
            pal_din  <= dma_data;
        end else begin
            pal_cs   <= 1'b0;
            pal_wrn  <= 1'b1;
        end
    end

endmodule

// File: rtl/jtkunio_paldma.sv
// Palette loader: copies LEN bytes from ROM into the colmix palette RAM during vblank.
module jtkunio_paldma
    import jtkunio_pkg::*;
#(
    parameter int unsigned AW     = PAL_AW,
    parameter int unsigned ROM_AW = 17,
    parameter int unsigned LEN    = DEF_LEN
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LVBL,
    input  logic              start,
    input  logic [ROM_AW-1:0] base,
    output logic              rom_cs,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    input  logic              cpu_pal_cs,
    input  logic              cpu_wrn,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic              pal_cs,
    output logic              pal_wrn,
    output logic [AW-1:0]     pal_addr,
    output logic [7:0]        pal_din,
    output logic              busy,
    output logic              done
);

    // index carries one extra bit so a full 2^AW transfer can be counted
    localparam int unsigned  IW   = AW + 1;
    localparam logic [IW-1:0] LAST = IW'(LEN - 1);

    paldma_state_t     state, state_nxt;
    logic [IW-1:0]     index, index_nxt;
    logic [ROM_AW-1:0] base_l, base_nxt;
    logic [7:0]        data_l, data_nxt;
    logic              dma_req_c;
    logic              defer_c;

    assign dma_req_c = (state == WR);

    // Next-state logic; blank end is only honoured between bytes
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        base_nxt  = base_l;
        data_nxt  = data_l;
        case (state)
            IDLE: begin
                if (start) begin
                    base_nxt  = base;
                    index_nxt = '0;
                    state_nxt = LVBL ? WAITVB : REQ;
                end
            end
            WAITVB: begin
                if (!LVBL) state_nxt = REQ;
            end
            REQ: begin
                // rom_cs is held until the ROM answers, even past blank end
                if (rom_ok) begin
                    data_nxt  = rom_data;
                    state_nxt = WR;
                end
            end
            WR: begin
                if (!defer_c) begin
                    if (index == LAST) begin
                        state_nxt = FIN;
                    end else begin
                        index_nxt = index + IW'(1);
                        state_nxt = LVBL ? WAITVB : REQ;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            base_l   <= '0;
            data_l   <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= state_nxt;
            index  <= index_nxt;
            base_l <= base_nxt;
            data_l <= data_nxt;
            rom_cs <= (state_nxt == REQ);
            if (state_nxt == REQ) begin
                rom_addr <= base_nxt + ROM_AW'(index_nxt);
            end
            busy <= (state_nxt == WAITVB) || (state_nxt == REQ) || (state_nxt == WR);
            done <= (state_nxt == FIN);
        end
    end

    jtkunio_paldma_mux #(
        .AW(AW)
    ) u_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_pal_cs (cpu_pal_cs),
        .cpu_wrn    (cpu_wrn),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .dma_req    (dma_req_c),
        .dma_addr   (index[AW-1:0]),
        .dma_data   (data_l),
        .defer_c    (defer_c),
        .pal_cs     (pal_cs),
        .pal_wrn    (pal_wrn),
        .pal_addr   (pal_addr),
        .pal_din    (pal_din)
    );

endmodule

// File: tb/tb_jtkunio_paldma.sv
// Directed bench for the jtkunio palette loader.
module tb_jtkunio_paldma;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        LVBL       = 1'b1;
    logic        start      = 1'b0;
    logic [16:0] base       = 17'h0;
    logic        rom_cs;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data   = 8'h00;
    logic        rom_ok     = 1'b0;
    logic        cpu_pal_cs = 1'b0;
    logic        cpu_wrn    = 1'b1;
    logic [8:0]  cpu_addr   = 9'h0;
    logic [7:0]  cpu_dout   = 8'h00;
    logic        pal_cs;
    logic        pal_wrn;
    logic [8:0]  pal_addr;
    logic [7:0]  pal_din;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtkunio_paldma #(
        .AW(9), .ROM_AW(17), .LEN(512)
    ) dut (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .start(start), .base(base),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .cpu_pal_cs(cpu_pal_cs), .cpu_wrn(cpu_wrn), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_cs(pal_cs), .pal_wrn(pal_wrn), .pal_addr(pal_addr), .pal_din(pal_din),
        .busy(busy), .done(done)
    );

    // ROM content model
    function automatic logic [7:0] rom_f(input logic [16:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd7;
        return t ^ a[15:8] ^ {a[16], 7'h25};
    endfunction

    // ROM responder: rom_ok two cycles after rom_cs, one cycle wide
    int ok_cnt = 0;
    always @(negedge clk) begin
        if (rom_ok) begin
            rom_ok = 1'b0;
            ok_cnt = 0;
        end else if (rom_cs) begin
            ok_cnt++;
            if (ok_cnt >= 2) begin
                rom_ok   = 1'b1;
                rom_data = rom_f(rom_addr);
            end
        end else begin
            ok_cnt = 0;
        end
    end

    // Bus monitor: loader writes must be in order with the model data
    int          dma_writes = 0;
    int          seq_err    = 0;
    int          done_cnt   = 0;
    int          rom_n      = 0;
    int          exp_base   = 0;
    logic        prev_cpu   = 1'b0;
    logic [16:0] rom_log [0:1023];
    always begin
        @(negedge clk);
        #2;
        if (pal_cs && !pal_wrn && !prev_cpu) begin
            if (pal_addr !== 9'(dma_writes) || pal_din !== rom_f(17'(exp_base + dma_writes)))
                seq_err++;
            dma_writes++;
        end
        if (done) done_cnt++;
        if (rom_ok && rom_n < 1024) begin
            rom_log[rom_n] = rom_addr;
            rom_n++;
        end
        prev_cpu = cpu_pal_cs;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log(input int b);
        dma_writes = 0;
        seq_err    = 0;
        done_cnt   = 0;
        rom_n      = 0;
        exp_base   = b;
    endtask

    task automatic pulse_start(input logic [16:0] b);
        base  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++; if (rom_cs !== 1'b0) begin fails++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
        tests++; if (rom_addr !== 17'h0) begin fails++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        tests++; if (pal_cs !== 1'b0 || pal_wrn !== 1'b1) begin fails++; $display("FAIL reset_pal_ctl: got cs=%b wrn=%b want cs=0 wrn=1", pal_cs, pal_wrn); end
        tests++; if (pal_addr !== 9'h0 || pal_din !== 8'h0) begin fails++; $display("FAIL reset_pal_bus: got %h/%h want 0/0", pal_addr, pal_din); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full();
        logic ok;
        LVBL = 1'b0;
        clear_log(32'h100);
        pulse_start(17'h00100);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL full_busy: got %b want 1", busy); end
        tests++; if (rom_cs !== 1'b1 || rom_addr !== 17'h00100) begin fails++; $display("FAIL full_first_req: got cs=%b addr=%h want cs=1 addr=00100", rom_cs, rom_addr); end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        tick();
        tick();
        tests++; if (!ok) begin fails++; $display("FAIL full_timeout: done got 0 want 1"); end
        tests++; if (dma_writes !== 512) begin fails++; $display("FAIL full_count: got %0d want 512", dma_writes); end
        tests++; if (seq_err !== 0) begin fails++; $display("FAIL full_data: got %0d bad writes want 0", seq_err); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL full_done_pulse: got %0d want 1", done_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_end: got %b want 0", busy); end
        tests++; if (rom_n !== 512) begin fails++; $display("FAIL full_rom_reads: got %0d want 512", rom_n); end
    endtask

    task automatic test_waitvb();
        logic ok;
        logic seen;
        LVBL = 1'b1;
        clear_log(32'h40);
        pulse_start(17'h00040);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rom_cs) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL waitvb_rom_cs: got 1 want 0 outside blank"); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL waitvb_busy: got %b want 1", busy); end
        LVBL = 1'b0;
        tick();
        tests++; if (rom_cs !== 1'b1 || rom_addr !== 17'h00040) begin fails++; $display("FAIL waitvb_first_req: got cs=%b addr=%h want cs=1 addr=00040", rom_cs, rom_addr); end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        tick();
        tick();
        tests++; if (!ok || dma_writes !== 512 || seq_err !== 0) begin fails++; $display("FAIL waitvb_transfer: got done=%b writes=%0d bad=%0d want 1/512/0", ok, dma_writes, seq_err); end
    endtask

    task automatic test_pause();
        logic ok;
        int   snap;
        LVBL = 1'b0;
        clear_log(32'h2000);
        pulse_start(17'h02000);
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (dma_writes >= 200) break;
        end
        LVBL = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        snap = dma_writes;
        for (int i = 0; i < 20; i++) tick();
        tests++; if (snap < 200 || snap > 202) begin fails++; $display("FAIL pause_point: got %0d writes want 200..202", snap); end
        tests++; if (dma_writes !== snap) begin fails++; $display("FAIL pause_hold: got %0d writes want %0d", dma_writes, snap); end
        tests++; if (rom_cs !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL pause_state: got cs=%b busy=%b want cs=0 busy=1", rom_cs, busy); end
        LVBL = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        tick();
        tick();
        tests++; if (!ok || dma_writes !== 512) begin fails++; $display("FAIL pause_count: got done=%b writes=%0d want 1/512", ok, dma_writes); end
        tests++; if (seq_err !== 0 || done_cnt !== 1) begin fails++; $display("FAIL pause_order: got bad=%0d done=%0d want 0/1", seq_err, done_cnt); end
    endtask

    task automatic test_cpu_priority();
        logic       ok;
        logic [8:0] ea;
        logic [7:0] ed;
        LVBL = 1'b0;
        clear_log(32'h300);
        pulse_start(17'h00300);
        for (int i = 0; i < 20; i++) begin
            if (rom_ok) break;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            cpu_pal_cs = 1'b1;
            cpu_wrn    = 1'b0;
            cpu_addr   = 9'h1A0 + 9'(k);
            cpu_dout   = 8'hC0 + 8'(k);
            tick();
            ea = 9'h1A0 + 9'(k);
            ed = 8'hC0 + 8'(k);
            tests++; if (pal_cs !== 1'b1 || pal_wrn !== 1'b0 || pal_addr !== ea || pal_din !== ed) begin
                fails++; $display("FAIL cpu_pass_%0d: got cs=%b wrn=%b %h/%h want 1/0 %h/%h", k, pal_cs, pal_wrn, pal_addr, pal_din, ea, ed);
            end
        end
        tests++; if (rom_cs !== 1'b0) begin fails++; $display("FAIL cpu_fsm_held: got rom_cs=%b want 0", rom_cs); end
        cpu_pal_cs = 1'b0;
        cpu_wrn    = 1'b1;
        tick();
        ed = rom_f(17'h00300);
        tests++; if (pal_cs !== 1'b1 || pal_wrn !== 1'b0 || pal_addr !== 9'h000 || pal_din !== ed) begin
            fails++; $display("FAIL cpu_dma_after: got cs=%b wrn=%b %h/%h want 1/0 000/%h", pal_cs, pal_wrn, pal_addr, pal_din, ed);
        end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        tick();
        tick();
        tests++; if (!ok || dma_writes !== 512 || seq_err !== 0) begin fails++; $display("FAIL cpu_transfer: got done=%b writes=%0d bad=%0d want 1/512/0", ok, dma_writes, seq_err); end
    endtask

    task automatic test_reset_midreq();
        logic ok;
        LVBL = 1'b0;
        clear_log(32'h500);
        pulse_start(17'h00500);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rom_cs && rom_n > 5) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (rom_cs !== 1'b0 || busy !== 1'b0 || pal_wrn !== 1'b1) begin fails++; $display("FAIL midreq_async: got cs=%b busy=%b wrn=%b want 0/0/1", rom_cs, busy, pal_wrn); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_log(32'h500);
        pulse_start(17'h00500);
        tests++; if (rom_cs !== 1'b1 || rom_addr !== 17'h00500) begin fails++; $display("FAIL midreq_restart: got cs=%b addr=%h want 1/00500", rom_cs, rom_addr); end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        tick();
        tick();
        tests++; if (!ok || dma_writes !== 512 || seq_err !== 0) begin fails++; $display("FAIL midreq_transfer: got done=%b writes=%0d bad=%0d want 1/512/0", ok, dma_writes, seq_err); end
    endtask

    task automatic test_wrap();
        logic ok;
        LVBL = 1'b0;
        clear_log(32'h1FFF0);
        pulse_start(17'h1FFF0);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (dma_writes >= 50) break;
        end
        pulse_start(17'h00010);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        pulse_start(17'h0AAAA);
        tick();
        tests++; if (!ok || dma_writes !== 512 || seq_err !== 0) begin fails++; $display("FAIL wrap_transfer: got done=%b writes=%0d bad=%0d want 1/512/0", ok, dma_writes, seq_err); end
        tests++; if (rom_log[15] !== 17'h1FFFF || rom_log[16] !== 17'h00000) begin fails++; $display("FAIL wrap_addr: got %h,%h want 1ffff,00000", rom_log[15], rom_log[16]); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL wrap_done_pulse: got %0d want 1", done_cnt); end
        for (int i = 0; i < 5; i++) tick();
        tests++; if (busy !== 1'b0 || rom_cs !== 1'b0) begin fails++; $display("FAIL start_at_done: got busy=%b cs=%b want 0/0", busy, rom_cs); end
    endtask

    initial begin
        test_reset();
        test_full();
        test_waitvb();
        test_pause();
        test_cpu_priority();
        test_reset_midreq();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
